// File: rtl/branch_pkg.sv
// branch_pkg: opcode encodings, predictor reset value and branch-class helper shared by the branch unit.
package branch_pkg;
  typedef enum logic [3:0] {
    OP_BLT  = 4'b1000,
    OP_BLTU = 4'b1001,
    OP_BLEZ = 4'b1010,
    OP_BEQ  = 4'b1011,
    OP_BNE  = 4'b1100,
    OP_BGEZ = 4'b1101,
    OP_BGTZ = 4'b1110,
    OP_BLTZ = 4'b1111
  } op_e;
  localparam logic [1:0] PRED_INIT = 2'b01;
  function automatic logic is_branch(input logic [3:0] op);
    return op >= OP_BLT;
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: request and result handshake bundle of the branch resolve unit.
interface branch_resolve_unit_if #(parameter int DATA_W = 32, parameter int PC_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_rs;
  logic [DATA_W-1:0] in_rt;
  logic [PC_W-1:0]   in_pc;
  logic [15:0]       in_offset;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic              out_pred;
  logic              out_mispredict;
  logic [PC_W-1:0]   out_next_pc;
  modport master(output in_valid, in_op, in_rs, in_rt, in_pc, in_offset, out_ready,
                 input in_ready, out_valid, out_taken, out_pred, out_mispredict, out_next_pc);
  modport slave(input in_valid, in_op, in_rs, in_rt, in_pc, in_offset, out_ready,
                output in_ready, out_valid, out_taken, out_pred, out_mispredict, out_next_pc);
endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluation; non-branch opcodes are never taken.
module branch_cond import branch_pkg::*; #(parameter int DATA_W = 32) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              taken
);
  logic ltz, lez;
  always_comb begin
    ltz = rs[DATA_W-1];
    lez = ltz | ~|rs;
    taken = (op == OP_BEQ)  ? rs == rt :
            (op == OP_BNE)  ? rs != rt :
            (op == OP_BLEZ) ? lez :
            (op == OP_BGTZ) ? !lez :
            (op == OP_BLTZ) ? ltz :
            (op == OP_BGEZ) ? !ltz :
            (op == OP_BLT)  ? $signed(rs) < $signed(rt) :
            (op == OP_BLTU) ? rs < rt : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches with a 2-bit predictor table, one-deep result register and stats.
module branch_resolve_unit import branch_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int PRED_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  branch_resolve_unit_if.slave bus,
  input  logic              flush,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts
);
  localparam int IW = $clog2(PRED_DEPTH);
  logic accept, load, br, taken, pred, mis;
  logic [IW-1:0] idx;
  logic [PC_W-1:0] seq_pc, tgt_pc;
  logic out_valid_q, out_valid_d, taken_q, taken_d, pred_q, pred_d, mis_q, mis_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic [PRED_DEPTH-1:0][1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  branch_cond #(.DATA_W(DATA_W)) u_cond (.op(bus.in_op), .rs(bus.in_rs), .rt(bus.in_rt), .taken(taken));
  assign bus.in_ready       = !Reset & (!out_valid_q | bus.out_ready);
  // held result is hidden during reset so no output handshake completes in that cycle
  assign bus.out_valid      = out_valid_q & !Reset;
  assign bus.out_taken      = taken_q;
  assign bus.out_pred       = pred_q;
  assign bus.out_mispredict = mis_q;
  assign bus.out_next_pc    = next_pc_q;
  assign stat_branches      = br_cnt_q;
  assign stat_mispredicts   = mis_cnt_q;
  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    load = accept & !flush;
    br = is_branch(bus.in_op);
    idx = bus.in_pc[IW+1:2];
    pred = ctr_q[idx][1];
    mis = br & (taken ^ pred);
    seq_pc = bus.in_pc + PC_W'(4);
    tgt_pc = seq_pc + PC_W'($signed({bus.in_offset, 2'b00}));
    out_valid_d = load | (out_valid_q & !flush & !bus.out_ready);
    taken_d = load ? taken : taken_q;
    pred_d = load ? pred : pred_q;
    mis_d = load ? mis : mis_q;
    next_pc_d = load ? (taken ? tgt_pc : seq_pc) : next_pc_q;
    ctr_d = ctr_q;
    ctr_d[idx] = !(accept & br) ? ctr_q[idx] :
                 taken ? (&ctr_q[idx] ? 2'd3 : ctr_q[idx] + 2'd1) :
                         (|ctr_q[idx] ? ctr_q[idx] - 2'd1 : 2'd0);
    br_cnt_d = stat_clear ? '0 : br_cnt_q + CNT_W'(accept & br & ~&br_cnt_q);
    mis_cnt_d = stat_clear ? '0 : mis_cnt_q + CNT_W'(accept & mis & ~&mis_cnt_q);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      taken_q <= 1'b0;
      pred_q <= 1'b0;
      mis_q <= 1'b0;
      next_pc_q <= '0;
      ctr_q <= {PRED_DEPTH{PRED_INIT}};
      br_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      taken_q <= taken_d;
      pred_q <= pred_d;
      mis_q <= mis_d;
      next_pc_q <= next_pc_d;
      ctr_q <= ctr_d;
      br_cnt_q <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus checked against a behavioural model plus literal expectations.
module tb_branch_resolve_unit;
  logic Clk = 0, Reset = 1, flush = 0, stat_clear = 0;
  logic [3:0] stat_branches, stat_mispredicts;
  int total = 0, bad = 0;
  branch_resolve_unit_if #(.DATA_W(32), .PC_W(32)) bus ();
  branch_resolve_unit #(.DATA_W(32), .PC_W(32), .PRED_DEPTH(16), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .flush(flush), .stat_clear(stat_clear),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));
  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic bit cond(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int s = $signed(rs);
    int t = $signed(rt);
    case (op)
      4'b1010: return s <= 0;
      4'b1011: return rs == rt;
      4'b1100: return rs != rt;
      4'b1101: return s >= 0;
      4'b1110: return s > 0;
      4'b1111: return s < 0;
      4'b1000: return s < t;
      4'b1001: return rs < rt;
      default: return 0;
    endcase
  endfunction

  bit m_ok = 0, m_valid = 0, m_taken = 0, m_pred = 0, m_mis = 0;
  logic [31:0] m_npc = 0;
  int ctr [16];
  int sb = 0, sm = 0;
  bit acc, br, t, p;
  int ix;
  always @(posedge Clk) begin
    if (Reset) begin
      m_ok = 1; m_valid = 0; m_taken = 0; m_pred = 0; m_mis = 0; m_npc = 0; sb = 0; sm = 0;
      for (int i = 0; i < 16; i++) ctr[i] = 1;
    end else begin
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      br = bus.in_op >= 4'd8;
      t = cond(bus.in_op, bus.in_rs, bus.in_rt);
      ix = int'(bus.in_pc / 4) % 16;
      p = ctr[ix] >= 2;
      if (stat_clear) begin sb = 0; sm = 0; end
      else if (acc && br) begin
        if (sb < 15) sb++;
        if (t != p && sm < 15) sm++;
      end
      if (acc && br) ctr[ix] = t ? (ctr[ix] == 3 ? 3 : ctr[ix] + 1) : (ctr[ix] == 0 ? 0 : ctr[ix] - 1);
      if (acc && !flush) begin
        m_valid = 1; m_taken = t; m_pred = p; m_mis = br && (t != p);
        m_npc = t ? 32'(longint'(bus.in_pc) + 4 + 4 * longint'($signed(bus.in_offset)))
                  : 32'(longint'(bus.in_pc) + 4);
      end else if (flush || bus.out_ready) m_valid = 0;
    end
  end

  always @(posedge Clk) begin
    #1;
    if (m_ok) begin
      chk("in_ready", bus.in_ready, !Reset && (!m_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, !Reset && m_valid);
      if (!Reset && m_valid) begin
        chk("out_taken", bus.out_taken, m_taken);
        chk("out_pred", bus.out_pred, m_pred);
        chk("out_mispredict", bus.out_mispredict, m_mis);
        chk("out_next_pc", bus.out_next_pc, m_npc);
      end
      chk("stat_branches", stat_branches, sb);
      chk("stat_mispredicts", stat_mispredicts, sm);
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] pc, input logic [15:0] off);
    bus.in_valid = 1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_pc = pc; bus.in_offset = off;
    @(negedge Clk);
    bus.in_valid = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ep [4] = '{0, 1, 1, 1};
    bit em [4] = '{1, 0, 0, 0};
    bus.in_valid = 0; bus.in_op = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_pc = 0; bus.in_offset = 0;
    bus.out_ready = 1;
    repeat (2) @(negedge Clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_taken", bus.out_taken, 0);
    chk("rst out_next_pc", bus.out_next_pc, 0);
    chk("rst stats", {stat_branches, stat_mispredicts}, 0);
    Reset = 0;
    send(4'b1011, 5, 5, 32'h100, 16'd4);
    chk("beq valid", bus.out_valid, 1);
    chk("beq taken", bus.out_taken, 1);
    chk("beq next_pc", bus.out_next_pc, 32'h114);
    send(4'b1010, 32'hFFFFFFFF, 0, 32'h200, 0);
    chk("blez taken", bus.out_taken, 1);
    send(4'b1110, 32'h80000000, 0, 32'h204, 0);
    chk("bgtz taken", bus.out_taken, 0);
    send(4'b1001, 1, 32'hFFFFFFFF, 32'h208, 0);
    chk("bltu taken", bus.out_taken, 1);
    send(4'b1000, 1, 32'hFFFFFFFF, 32'h20C, 0);
    chk("blt taken", bus.out_taken, 0);
    send(4'b0011, 1, 1, 32'h210, 16'd8);
    chk("nonbranch mis", bus.out_mispredict, 0);
    chk("nonbranch next_pc", bus.out_next_pc, 32'h214);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(4'b1011, 3, 3, 32'h40, 0);
      chk("pred seq", bus.out_pred, ep[i]);
      chk("mis seq", bus.out_mispredict, em[i]);
    end
    chk("stat_branches 4", stat_branches, 4);
    chk("stat_mispredicts 1", stat_mispredicts, 1);
    @(negedge Clk);
    bus.out_ready = 0;
    send(4'b1100, 1, 2, 32'h300, 16'd8);
    bus.in_valid = 1; bus.in_op = 4'b1011; bus.in_rs = 7; bus.in_rt = 7; bus.in_pc = 32'h500; bus.in_offset = 16'hFFFF;
    repeat (3) begin
      @(negedge Clk);
      chk("stall in_ready", bus.in_ready, 0);
      chk("stall valid", bus.out_valid, 1);
      chk("stall next_pc", bus.out_next_pc, 32'h324);
    end
    bus.out_ready = 1;
    #1 chk("release in_ready", bus.in_ready, 1);
    @(negedge Clk);
    bus.in_valid = 0;
    chk("replace valid", bus.out_valid, 1);
    chk("replace next_pc", bus.out_next_pc, 32'h500);
    send(4'b1011, 1, 1, 32'h600, 0);
    flush = 1;
    send(4'b1101, 0, 0, 32'h700, 0);
    flush = 0;
    chk("flush valid", bus.out_valid, 0);
    chk("flush stat_branches", stat_branches, 8);
    stat_clear = 1;
    send(4'b1011, 2, 2, 32'h800, 0);
    stat_clear = 0;
    chk("clear stats", {stat_branches, stat_mispredicts}, 0);
    send(4'b1100, 1, 2, 32'hFFFFFFFC, 0);
    chk("wrap taken", bus.out_taken, 1);
    chk("wrap next_pc", bus.out_next_pc, 0);
    bus.out_ready = 0;
    Reset = 1;
    #1 chk("reset in_ready", bus.in_ready, 0);
    @(negedge Clk);
    chk("reset drops valid", bus.out_valid, 0);
    Reset = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] rs, rt;
      rs = 32'(i * 37 - 300);
      rt = (i % 3 == 0) ? rs : 32'(i * 11 - 50);
      bus.out_ready = (i % 4 != 3);
      send((i % 5 == 4) ? 4'b0011 : 4'b1000 + 4'(i % 8), rs, rt, 32'(i * 4), 16'(i * 3 - 20));
    end
    bus.out_ready = 1;
    @(negedge Clk);
    stat_clear = 1;
    @(negedge Clk);
    stat_clear = 0;
    repeat (17) send(4'b1011, 9, 9, 32'h1000, 0);
    chk("stat saturate", stat_branches, 15);
    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
